// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - instruction memory loader: host byte stream to 32-bit word writes, core reset release
//
// Collects little-endian bytes from a host valid/ready byte stream. It assembles them into
// 32-bit words and writes each word to instruction memory at base_addr + word index.
// When all words are written it releases the core from reset.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        begin a load (base_addr/load_len sampled) / cancel it
//   base_addr, load_len first word address and word count
//   byte_valid/_data    host byte stream in; byte_ready out
//   mem_write_*         memory write port (address, data, level enable)
//   cpu_fetch_addr      core fetch address, forwarded to mem_read_addr
//   core_rst_n          core reset, high only once the image is loaded
//   busy, done          load in progress / load complete
module imem_load_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] load_len,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_en,
    input  logic [ADDR_WIDTH-1:0] cpu_fetch_addr,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0]   word_idx_q, word_idx_d;
    logic [ADDR_WIDTH-1:0]   len_q, len_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [23:0]             partial_q, partial_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    wr_en_q, wr_en_d;
    logic                    byte_ready_q, byte_ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    core_rst_n_q, core_rst_n_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            len_q        <= '0;
            base_q       <= '0;
            partial_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_idx_q   <= word_idx_d;
            len_q        <= len_d;
            base_q       <= base_d;
            partial_q    <= partial_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    // Next state and datapath updates
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        base_d     = base_q;
        partial_d  = partial_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    base_d     = base_addr;
                    len_d      = load_len;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    state_d    = (load_len == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                // Abort wins over a byte offered in the same cycle; that byte stays with the host.
                if (abort) begin
                    byte_cnt_d = '0;
                    state_d    = S_IDLE;
                end else if (byte_valid) begin
                    if (byte_cnt_q == 2'd3) begin
                        // Address/data only change here, so they are stable across the write cycle.
                        wr_addr_d  = base_q + word_idx_q;
                        wr_data_d  = {byte_data, partial_q};
                        byte_cnt_d = '0;
                        state_d    = S_WRITE;
                    end else begin
                        case (byte_cnt_q)
                            2'd0:    partial_d[7:0]   = byte_data;
                            2'd1:    partial_d[15:8]  = byte_data;
                            default: partial_d[23:16] = byte_data;
                        endcase
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                // The write itself always completes; abort only changes where we go next.
                word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                if (abort) begin
                    state_d = S_IDLE;
                end else if (word_idx_q + ADDR_WIDTH'(1) == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registered copies line up with state_q
    always_comb begin
        byte_ready_d = (state_d == S_COLLECT);
        wr_en_d      = (state_d == S_WRITE);
        busy_d       = (state_d == S_COLLECT) || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        core_rst_n_d = (state_d == S_DONE);
    end

    assign byte_ready     = byte_ready_q;
    assign mem_write_addr = wr_addr_q;
    assign mem_write_data = wr_data_q;
    assign mem_write_en   = wr_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign core_rst_n     = core_rst_n_q;
    assign mem_read_addr  = cpu_fetch_addr;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - scoreboard testbench for imem_load_ctrl
module tb_imem_load_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] base_addr;
    logic [15:0] load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [15:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_en;
    logic [15:0] cpu_fetch_addr;
    logic [15:0] mem_read_addr;
    logic        core_rst_n;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;

    logic [7:0]  byte_q[$];
    logic [15:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic        prev_en = 1'b0;

    imem_load_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .base_addr      (base_addr),
        .load_len       (load_len),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .cpu_fetch_addr (cpu_fetch_addr),
        .mem_read_addr  (mem_read_addr),
        .core_rst_n     (core_rst_n),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write-enable cycle is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n && mem_write_en) begin
            writes_seen++;
            check("wr_en_one_cycle", {31'd0, prev_en}, 32'd0);
            if (exp_addr_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                check("wr_addr", {16'd0, mem_write_addr}, {16'd0, exp_addr_q.pop_front()});
                check("wr_data", mem_write_data, exp_data_q.pop_front());
            end
        end
        prev_en <= rst_n && mem_write_en;
    end

    task automatic do_start(input logic [15:0] base, input logic [15:0] len);
        @(negedge clk);
        base_addr = base;
        load_len  = len;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = $urandom;
        load_len  = $urandom;
    endtask

    // Offers bytes from byte_q with random gaps in byte_valid; returns just after the edge taking byte n.
    task automatic feed(input int n);
        int  sent  = 0;
        int  guard = 0;
        logic acc;
        while (sent < n && guard < 2000) begin
            @(negedge clk);
            byte_valid = ($urandom_range(0, 3) != 0);
            byte_data  = byte_q[0];
            acc = byte_valid && byte_ready;
            @(posedge clk);
            if (acc) begin
                void'(byte_q.pop_front());
                sent++;
            end
            guard++;
        end
        #1;
        byte_valid = 1'b0;
        if (sent < n) check("feed_timeout", sent, n);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
        check("core_rst_released", {31'd0, core_rst_n}, 32'd1);
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    // Reference model: word i is bytes 4i..4i+3 little-endian at (base+i) mod 2^16.
    task automatic gen_words(input logic [15:0] base, input int len, input logic push_exp);
        logic [31:0] w;
        logic [7:0]  b;
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'($urandom);
                byte_q.push_back(b);
                w[k*8 +: 8] = b;
            end
            if (push_exp) begin
                exp_addr_q.push_back(16'(base + 16'(i)));
                exp_data_q.push_back(w);
            end
        end
    endtask

    task automatic load(input logic [15:0] base, input int len);
        do_start(base, 16'(len));
        gen_words(base, len, 1'b1);
        feed(4 * len);
        wait_done();
    endtask

    initial begin
        int ws;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; load_len = '0; byte_valid = 1'b0; byte_data = '0;
        cpu_fetch_addr = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_wr_en",   {31'd0, mem_write_en}, 32'd0);
        check("rst_ready",   {31'd0, byte_ready}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_done",    {31'd0, done}, 32'd0);
        check("rst_core",    {31'd0, core_rst_n}, 32'd0);
        check("rst_wr_addr", {16'd0, mem_write_addr}, 32'd0);
        check("rst_wr_data", mem_write_data, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_fetch_addr = 16'($urandom);
            #1 check("read_addr_passthru", {16'd0, mem_read_addr}, {16'd0, cpu_fetch_addr});
        end

        // Zero-length load: straight to DONE, no write.
        ws = writes_seen;
        do_start(16'h1234, 16'd0);
        check("len0_done",  {31'd0, done}, 32'd1);
        check("len0_core",  {31'd0, core_rst_n}, 32'd1);
        check("len0_busy",  {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("len0_no_write", writes_seen, ws);

        // Directed load from DONE: core reset and done drop on the next edge.
        do_start(16'h0010, 16'd2);
        check("restart_done_low", {31'd0, done}, 32'd0);
        check("restart_core_low", {31'd0, core_rst_n}, 32'd0);
        check("restart_busy",     {31'd0, busy}, 32'd1);
        check("restart_ready",    {31'd0, byte_ready}, 32'd1);
        for (int k = 1; k <= 8; k++) byte_q.push_back(8'(k * 8'h11));
        exp_addr_q.push_back(16'h0010); exp_data_q.push_back(32'h44332211);
        exp_addr_q.push_back(16'h0011); exp_data_q.push_back(32'h88776655);
        feed(8);
        wait_done();

        // Address wrap.
        exp_addr_q.push_back(16'hFFFF); exp_addr_q.push_back(16'h0000);
        do_start(16'hFFFF, 16'd2);
        gen_words(16'hFFFF, 2, 1'b0);
        for (int i = 0; i < 2; i++)
            exp_data_q.push_back({byte_q[4*i+3], byte_q[4*i+2], byte_q[4*i+1], byte_q[4*i]});
        feed(8);
        wait_done();

        // Abort after 3 bytes, with a byte offered in the abort cycle.
        ws = writes_seen;
        do_start(16'h0040, 16'd2);
        byte_q.push_back(8'hA1); byte_q.push_back(8'hA2); byte_q.push_back(8'hA3);
        feed(3);
        @(negedge clk);
        abort = 1'b1; byte_valid = 1'b1; byte_data = 8'hEE;
        @(posedge clk);
        #1 abort = 1'b0; byte_valid = 1'b0;
        check("abort_busy",  {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, byte_ready}, 32'd0);
        check("abort_core",  {31'd0, core_rst_n}, 32'd0);
        check("abort_done",  {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_write", writes_seen, ws);
        load(16'h0040, 2);

        // Random loads.
        for (int t = 0; t < 4; t++) load(16'($urandom), $urandom_range(1, 5));

        // Abort during WRITE: that write completes, then IDLE.
        do_start(16'h0200, 16'd3);
        gen_words(16'h0200, 1, 1'b1);
        feed(4);
        check("wr_en_in_write", {31'd0, mem_write_en}, 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_wr_busy", {31'd0, busy}, 32'd0);
        check("abort_wr_en",   {31'd0, mem_write_en}, 32'd0);
        check("abort_wr_done", {31'd0, done}, 32'd0);

        // Reset pulsed during WRITE: outputs clear without waiting for a clock edge.
        do_start(16'h0300, 16'd1);
        gen_words(16'h0300, 1, 1'b0);
        feed(4);
        check("pre_rst_wr_en", {31'd0, mem_write_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en",   {31'd0, mem_write_en}, 32'd0);
        check("mid_rst_ready",   {31'd0, byte_ready}, 32'd0);
        check("mid_rst_busy",    {31'd0, busy}, 32'd0);
        check("mid_rst_done",    {31'd0, done}, 32'd0);
        check("mid_rst_core",    {31'd0, core_rst_n}, 32'd0);
        check("mid_rst_wr_addr", {16'd0, mem_write_addr}, 32'd0);
        check("mid_rst_wr_data", mem_write_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load(16'h0500, 3);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_addr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word width; fixed at 32, since the block assembles 4 bytes per word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning the instruction memory word-address width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  meaning a one-cycle pulse that begins a load.
REQ-006 SHALL have port abort  input  1  meaning cancel the load in progress.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  meaning the first word address, sampled on start.
REQ-008 SHALL have port load_len  input  ADDR_WIDTH  meaning the number of words to load, sampled on start.
REQ-009 SHALL have port byte_valid  input  1  meaning host byte available.
REQ-010 SHALL have port byte_data  input  8  meaning host byte.
REQ-011 SHALL have port byte_ready  output  1  meaning the byte is accepted this cycle when byte_valid is also high.
REQ-012 SHALL have port mem_write_addr  output  ADDR_WIDTH  meaning the memory write address.
REQ-013 SHALL have port mem_write_data  output  DATA_WIDTH  meaning the memory write data.
REQ-014 SHALL have port mem_write_en  output  1  meaning the level-sensitive memory write enable.
REQ-015 SHALL have port cpu_fetch_addr  input  ADDR_WIDTH  meaning the core fetch address.
REQ-016 SHALL have port mem_read_addr  output  ADDR_WIDTH  meaning the memory read address.
REQ-017 SHALL have port core_rst_n  output  1  meaning the core reset, low while not loaded.
REQ-018 SHALL have ports busy and done  output  1 each  meaning load in progress / load complete.

Function
REQ-019 SHALL implement states IDLE, COLLECT, WRITE and DONE.
REQ-020 SHALL move from IDLE or DONE to COLLECT on start when the sampled load_len is nonzero, and SHALL move straight to DONE with no write when load_len is 0.
REQ-021 SHALL ignore start while in COLLECT or WRITE.
REQ-022 SHALL drive byte_ready high only in COLLECT; a byte transfers when byte_valid and byte_ready are both high.
REQ-023 SHALL assemble each word little-endian: the first byte goes to bits [7:0] and the fourth byte to bits [31:24].
REQ-024 SHALL update mem_write_addr (base plus word index, modulo 2^ADDR_WIDTH) and mem_write_data on the edge that accepts the 4th byte, then enter WRITE.
REQ-025 SHALL hold mem_write_en high for exactly the one cycle spent in WRITE; mem_write_en SHALL be registered and glitch-free.
REQ-026 SHALL hold mem_write_addr and mem_write_data stable from the cycle before WRITE until the next 4th-byte acceptance, so address and data never change while mem_write_en is high.
REQ-027 SHALL, on leaving WRITE, increment the word index and go to DONE if the index equals load_len, otherwise go to COLLECT.
REQ-028 SHALL wrap the write address from 2^ADDR_WIDTH-1 to 0.
REQ-029 SHALL, on abort in COLLECT, go to IDLE next cycle, discard the partial word and perform no write.
REQ-030 SHALL, on abort in WRITE, complete the write and then go to IDLE.
REQ-031 SHALL ignore abort in IDLE and DONE.
REQ-032 SHALL give abort priority over byte acceptance in the same cycle; that byte is not consumed.
REQ-033 SHALL drive busy high in COLLECT and WRITE, drive done high only in DONE, and drive core_rst_n high only in DONE; all three SHALL be registered.
REQ-034 SHALL, on start in DONE, drop core_rst_n and done on the next edge.
REQ-035 SHALL drive mem_read_addr combinationally equal to cpu_fetch_addr in all states.

Reset
REQ-036 SHALL, while rst_n is low, immediately set the state to IDLE and the byte count and word index to 0.
REQ-037 SHALL, while rst_n is low, drive mem_write_en=0, byte_ready=0, busy=0, done=0 and core_rst_n=0.
REQ-038 SHALL, while rst_n is low, drive mem_write_addr=0 and mem_write_data=0.
REQ-039 SHALL, on reset assertion mid-load (including during WRITE), drop mem_write_en at once; the load is lost.

Verification
REQ-040 Bench SHALL cover: base_addr=0x0010, load_len=2, bytes 11 22 33 44 55 66 77 88 -> write 0x44332211 @0x0010, then 0x88776655 @0x0011, each with a 1-cycle write_en; then done=1 and core_rst_n=1.
REQ-041 Bench SHALL cover: load_len=0 with start -> DONE next cycle, no mem_write_en pulse.
REQ-042 Bench SHALL cover: base_addr=0xFFFF, load_len=2 -> writes at 0xFFFF then 0x0000.
REQ-043 Bench SHALL cover: abort after 3 bytes -> IDLE, no write, busy=0, core_rst_n=0; a new start then loads correctly.
REQ-044 Bench SHALL cover: byte_valid toggling randomly, and rst_n pulsed low during WRITE -> mem_write_en=0 immediately, all outputs at reset values.
